// File: rtl/ucode_loader_pkg.sv
// Shared constants for the microcode loader: command/reply bytes and the
// loader state enumeration.
package ucode_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_GO    = 8'h47;  // 'G'
  localparam logic [7:0] CMD_STOP  = 8'h53;  // 'S'

  localparam logic [7:0] RPL_OK    = 8'h2B;  // '+'
  localparam logic [7:0] RPL_DONE  = 8'h2E;  // '.'
  localparam logic [7:0] RPL_UNK   = 8'h3F;  // '?'
  localparam logic [7:0] RPL_ERR   = 8'h45;  // 'E'
  localparam logic [7:0] RPL_FAULT = 8'h21;  // '!'
  localparam logic [7:0] RPL_ZERO  = 8'h30;  // '0'
  localparam logic [7:0] RPL_ONE   = 8'h31;  // '1'

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DHI   = 3'd2,
    ST_DLO   = 3'd3,
    ST_REPLY = 3'd4,
    ST_RUN   = 3'd5
  } state_e;

endpackage

// File: rtl/ucode_loader.sv
// Byte-stream microcode loader: parses load/go/stop commands from a serial
// receiver, writes 16-bit words into uCode memory and replies one byte per command.
module ucode_loader
  import ucode_pkg::*;
#(
  parameter int ADDR_SZ = 10,
  parameter int DATA_SZ = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_rx_wr,
  input  logic [7:0]         i_rx_data,
  input  logic               i_tx_busy,
  output logic               o_tx_wr,
  output logic [7:0]         o_tx_data,
  output logic               o_mem_wr,
  output logic [ADDR_SZ-1:0] o_mem_addr,
  output logic [DATA_SZ-1:0] o_mem_data,
  output logic               o_cpu_run,
  input  logic               i_cpu_running,
  input  logic               i_cpu_status,
  output logic               o_error
);

  // Strobe semantics: i_rx_wr, o_tx_wr and o_mem_wr are single-cycle qualifiers
  // with no back-pressure; the only flow control is i_tx_busy, which holds a
  // queued reply in REPLY until the transmitter is free.

  state_e               r_state;
  state_e               r_ret;
  logic [1:0]           r_hdr_idx;
  logic [7:0]           r_hdr_hi;
  logic [7:0]           r_data_hi;
  logic [ADDR_SZ-1:0]   r_addr;
  logic [15:0]          r_cnt;
  logic                 r_tx_wr;
  logic [7:0]           r_tx_data;
  logic                 r_mem_wr;
  logic [ADDR_SZ-1:0]   r_mem_addr;
  logic [DATA_SZ-1:0]   r_mem_data;
  logic                 r_cpu_run;
  logic                 r_error;
  logic                 r_low_seen;

  state_e               w_state_nxt;
  state_e               w_ret_nxt;
  logic                 w_queue;
  logic [7:0]           w_queue_byte;
  logic                 w_run_set;
  logic                 w_run_clr;
  logic                 w_err_set;
  logic                 w_mem_wr;
  logic                 w_tx_wr;
  logic                 w_fault;

  // Second consecutive cycle of "run requested but CPU idle"; the first is skew.
  assign w_fault = (r_state == ST_RUN) && r_cpu_run && r_low_seen && !i_cpu_running;

  always_comb begin
    w_state_nxt  = r_state;
    w_ret_nxt    = r_ret;
    w_queue      = 1'b0;
    w_queue_byte = r_tx_data;
    w_run_set    = 1'b0;
    w_run_clr    = 1'b0;
    w_err_set    = 1'b0;
    w_mem_wr     = 1'b0;
    w_tx_wr      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_rx_wr) begin
          if (i_rx_data == CMD_LOAD) begin
            w_state_nxt = ST_HDR;
          end else if (i_rx_data == CMD_GO) begin
            w_run_set    = 1'b1;
            w_queue      = 1'b1;
            w_queue_byte = RPL_OK;
            w_ret_nxt    = ST_RUN;
            w_state_nxt  = ST_REPLY;
          end else begin
            w_queue      = 1'b1;
            w_queue_byte = RPL_UNK;
            w_ret_nxt    = ST_IDLE;
            w_state_nxt  = ST_REPLY;
          end
        end
      end
      ST_HDR: begin
        if (i_rx_wr && (r_hdr_idx == 2'd3)) begin
          if ({r_cnt[15:8], i_rx_data} == 16'd0) begin
            w_queue      = 1'b1;
            w_queue_byte = RPL_DONE;
            w_ret_nxt    = ST_IDLE;
            w_state_nxt  = ST_REPLY;
          end else begin
            w_state_nxt = ST_DHI;
          end
        end
      end
      ST_DHI: begin
        if (i_rx_wr) w_state_nxt = ST_DLO;
      end
      ST_DLO: begin
        if (i_rx_wr) begin
          w_mem_wr = !r_cpu_run;
          if (r_cnt == 16'd1) begin
            w_queue      = 1'b1;
            w_queue_byte = RPL_DONE;
            w_ret_nxt    = ST_IDLE;
            w_state_nxt  = ST_REPLY;
          end else begin
            w_state_nxt = ST_DHI;
          end
        end
      end
      ST_REPLY: begin
        w_err_set = i_rx_wr;
        if (!i_tx_busy) begin
          w_tx_wr     = 1'b1;
          w_state_nxt = r_ret;
        end
      end
      ST_RUN: begin
        if (w_fault) begin
          w_run_clr    = 1'b1;
          w_err_set    = i_rx_wr;
          w_queue      = 1'b1;
          w_queue_byte = RPL_FAULT;
          w_ret_nxt    = ST_IDLE;
          w_state_nxt  = ST_REPLY;
        end else if (i_rx_wr) begin
          w_queue     = 1'b1;
          w_state_nxt = ST_REPLY;
          if (i_rx_data == CMD_STOP) begin
            w_run_clr    = 1'b1;
            w_queue_byte = i_cpu_status ? RPL_ONE : RPL_ZERO;
            w_ret_nxt    = ST_IDLE;
          end else begin
            w_queue_byte = RPL_ERR;
            w_ret_nxt    = ST_RUN;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_ret   <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
      r_ret   <= w_ret_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hdr_idx  <= '0;
      r_hdr_hi   <= '0;
      r_data_hi  <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_tx_wr    <= 1'b0;
      r_tx_data  <= '0;
      r_mem_wr   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_cpu_run  <= 1'b0;
      r_error    <= 1'b0;
      r_low_seen <= 1'b0;
    end else begin
      r_tx_wr    <= w_tx_wr;
      r_mem_wr   <= w_mem_wr;
      r_low_seen <= r_cpu_run && !i_cpu_running;
      if (w_queue)   r_tx_data <= w_queue_byte;
      if (w_err_set) r_error   <= 1'b1;
      if (w_run_set)      r_cpu_run <= 1'b1;
      else if (w_run_clr) r_cpu_run <= 1'b0;
      if (i_rx_wr) begin
        case (r_state)
          ST_IDLE: r_hdr_idx <= 2'd0;
          ST_HDR: begin
            r_hdr_idx <= r_hdr_idx + 2'd1;
            case (r_hdr_idx)
              2'd0:    r_hdr_hi   <= i_rx_data;
              2'd1:    r_addr     <= ADDR_SZ'({r_hdr_hi, i_rx_data});
              2'd2:    r_cnt[15:8] <= i_rx_data;
              default: r_cnt[7:0]  <= i_rx_data;
            endcase
          end
          ST_DHI: r_data_hi <= i_rx_data;
          ST_DLO: begin
            r_mem_addr <= r_addr;
            r_mem_data <= {r_data_hi, i_rx_data};
            r_addr     <= r_addr + 1'b1;
            r_cnt      <= r_cnt - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_tx_wr    = r_tx_wr;
  assign o_tx_data  = r_tx_data;
  assign o_mem_wr   = r_mem_wr;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_data = r_mem_data;
  assign o_cpu_run  = r_cpu_run;
  assign o_error    = r_error;

endmodule

// File: tb/tb_ucode_loader.sv
// Directed scoreboard bench for ucode_loader: expected tx bytes and memory
// writes are queued at stimulus time and popped by an independent monitor.
module tb_ucode_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_wr = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_busy = 1'b0;
  logic          tx_wr;
  logic [7:0]    tx_data;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic          cpu_run;
  logic          cpu_running = 1'b0;
  logic          cpu_status = 1'b0;
  logic          error;

  int total = 0;
  int bad = 0;

  logic [7:0]       exp_q[$];
  logic [AW+15:0]   exp_mem_q[$];

  ucode_loader #(.ADDR_SZ(AW), .DATA_SZ(16)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_rx_wr(rx_wr),
    .i_rx_data(rx_data),
    .i_tx_busy(tx_busy),
    .o_tx_wr(tx_wr),
    .o_tx_data(tx_data),
    .o_mem_wr(mem_wr),
    .o_mem_addr(mem_addr),
    .o_mem_data(mem_data),
    .o_cpu_run(cpu_run),
    .i_cpu_running(cpu_running),
    .i_cpu_status(cpu_status),
    .o_error(error)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_wr"},    {31'd0, tx_wr},    32'd0);
    check({tag, "_tx_data"},  {24'd0, tx_data},  32'd0);
    check({tag, "_mem_wr"},   {31'd0, mem_wr},   32'd0);
    check({tag, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
    check({tag, "_mem_data"}, {16'd0, mem_data}, 32'd0);
    check({tag, "_cpu_run"},  {31'd0, cpu_run},  32'd0);
    check({tag, "_error"},    {31'd0, error},    32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_wr   = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_wr   = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] seq[$]);
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || exp_mem_q.size() != 0); i++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    check({name, "_drain"}, exp_q.size() + exp_mem_q.size(), 32'd0);
    exp_q.delete();
    exp_mem_q.delete();
  endtask

  // scoreboard monitor
  initial begin
    logic [7:0]     e_tx;
    logic [AW+15:0] e_mem;
    forever begin
      @(posedge clk);
      #1;
      if (tx_wr) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL tx_unexpected: got %0h want none", tx_data);
        end else begin
          e_tx = exp_q.pop_front();
          if (tx_data !== e_tx) begin
            bad++;
            $display("FAIL tx_byte: got %0h want %0h", tx_data, e_tx);
          end
        end
      end
      if (mem_wr) begin
        total++;
        if (exp_mem_q.size() == 0) begin
          bad++;
          $display("FAIL mem_unexpected: got %0h/%0h want none", mem_addr, mem_data);
        end else begin
          e_mem = exp_mem_q.pop_front();
          if ({mem_addr, mem_data} !== e_mem || cpu_run !== 1'b0) begin
            bad++;
            $display("FAIL mem_write: got %0h/%0h run=%0b want %0h/%0h run=0",
                     mem_addr, mem_data, cpu_run, e_mem[AW+15:16], e_mem[15:0]);
          end
        end
      end
    end
  end

  initial begin
    #3 check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // load two words
    exp_mem_q.push_back({10'h020, 16'h1234});
    exp_mem_q.push_back({10'h021, 16'hABCD});
    exp_q.push_back(8'h2E);
    send_seq('{8'h4C, 8'h00, 8'h20, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD});
    wait_drain("load");

    // address wrap at the top of memory
    exp_mem_q.push_back({10'h3FF, 16'h1111});
    exp_mem_q.push_back({10'h000, 16'h2222});
    exp_q.push_back(8'h2E);
    send_seq('{8'h4C, 8'h03, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22});
    wait_drain("wrap");

    // zero-length load
    exp_q.push_back(8'h2E);
    send_seq('{8'h4C, 8'h01, 8'h00, 8'h00, 8'h00});
    wait_drain("count0");

    // run / stop with status OK
    cpu_running = 1'b1;
    cpu_status  = 1'b1;
    exp_q.push_back(8'h2B);
    send_byte(8'h47);
    wait_drain("go");
    check("run_set", {31'd0, cpu_run}, 32'd1);
    exp_q.push_back(8'h31);
    send_byte(8'h53);
    wait_drain("stop1");
    check("run_clr", {31'd0, cpu_run}, 32'd0);

    // 'L' while running -> 'E', run held, no write; then stop with status 0
    cpu_status = 1'b0;
    exp_q.push_back(8'h2B);
    send_byte(8'h47);
    wait_drain("go2");
    exp_q.push_back(8'h45);
    send_byte(8'h4C);
    wait_drain("run_l");
    check("run_kept", {31'd0, cpu_run}, 32'd1);
    exp_q.push_back(8'h30);
    send_byte(8'h53);
    wait_drain("stop0");
    check("err_clean", {31'd0, error}, 32'd0);

    // CPU fault: never comes up after 'G'
    cpu_running = 1'b0;
    exp_q.push_back(8'h2B);
    exp_q.push_back(8'h21);
    send_byte(8'h47);
    wait_drain("fault");
    check("fault_run", {31'd0, cpu_run}, 32'd0);
    check("fault_err", {31'd0, error}, 32'd0);

    // rx in the fault cycle is discarded, fault wins
    exp_q.push_back(8'h2B);
    exp_q.push_back(8'h21);
    send_byte(8'h47);
    send_byte(8'h53);
    wait_drain("fault_rx");
    check("fault_rx_run", {31'd0, cpu_run}, 32'd0);
    check("fault_rx_err", {31'd0, error}, 32'd1);
    pulse_reset("rst_err");

    // busy transmitter plus overrun byte
    tx_busy = 1'b1;
    exp_q.push_back(8'h3F);
    send_byte(8'h58);
    send_byte(8'h59);
    repeat (4) @(negedge clk);
    check("busy_hold", exp_q.size(), 32'd1);
    check("overrun_err", {31'd0, error}, 32'd1);
    tx_busy = 1'b0;
    wait_drain("busy");
    check("err_sticky", {31'd0, error}, 32'd1);
    pulse_reset("rst_busy");

    // reset mid-load after the first word
    exp_mem_q.push_back({10'h020, 16'h1234});
    send_seq('{8'h4C, 8'h00, 8'h20, 8'h00, 8'h05, 8'h12, 8'h34});
    repeat (2) @(negedge clk);
    check("midload_one", exp_mem_q.size(), 32'd0);
    pulse_reset("rst_load");
    cpu_running = 1'b1;
    exp_q.push_back(8'h2B);
    send_byte(8'h47);
    wait_drain("go_after_rst");
    check("run_after_rst", {31'd0, cpu_run}, 32'd1);

    // asynchronous drop of run on reset
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_run_async", {31'd0, cpu_run}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("final_run", {31'd0, cpu_run}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
